pc_fetch_unit: RTL

//  Instruction-fetch stage directly upstream of the instruction memory: owns the PC and drives the IMEM byte address.

---
 rtl/pc_fetch_unit_pkg.sv | 15 +
 rtl/pc_next_mux.sv | 52 +++++
 rtl/pc_fetch_unit.sv | 94 +++++++++
 3 files changed

// File: rtl/pc_fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: NOP encoding, reset PC
// and the next-PC select encoding used between the fetch top and pc_next_mux.
package pc_fetch_unit_pkg;

  localparam logic [31:0] MIPS_NOP      = 32'h0000_0000;
  localparam logic [31:0] MIPS_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    NPC_SEQ = 2'd0,
    NPC_BR  = 2'd1,
    NPC_J   = 2'd2,
    NPC_JR  = 2'd3
  } npc_sel_e;

endpackage

// File: rtl/pc_next_mux.sv
// Combinational next-PC selection: branch/jump/jump-register targets and their
// priority, honoured only when the instruction sitting in IF/ID is valid.
module pc_next_mux
  import pc_fetch_unit_pkg::*;
(
  input  logic               [31:0] seq_pc,
  input  logic               [31:0] ifid_pc_plus4,
  input  logic                      ifid_valid,
  input  logic                      branch_taken,
  input  logic signed        [31:0] branch_imm,
  input  logic                      jump,
  input  logic               [25:0] jump_index,
  input  logic                      jump_reg,
  input  logic               [31:0] jr_addr,
  output npc_sel_e                  npc_sel,
  output logic               [31:0] next_pc,
  output logic                      jr_misaligned
);

  logic signed [31:0] br_off;
  logic        [31:0] br_target;
  logic        [31:0] j_target;
  logic        [31:0] jr_target;

  // Word offset scaled to bytes; the add wraps modulo 2^32.
  assign br_off    = branch_imm <<< 2;
  assign br_target = ifid_pc_plus4 + $unsigned(br_off);
  assign j_target  = {ifid_pc_plus4[31:28], jump_index, 2'b00};
  assign jr_target = {jr_addr[31:2], 2'b00};

  always_comb begin
    npc_sel = NPC_SEQ;
    if (ifid_valid) begin
      if (jump_reg)          npc_sel = NPC_JR;
      else if (jump)         npc_sel = NPC_J;
      else if (branch_taken) npc_sel = NPC_BR;
    end
  end

  always_comb begin
    next_pc = seq_pc;
    case (npc_sel)
      NPC_BR:  next_pc = br_target;
      NPC_J:   next_pc = j_target;
      NPC_JR:  next_pc = jr_target;
      default: next_pc = seq_pc;
    endcase
  end

  assign jr_misaligned = (npc_sel == NPC_JR) && (jr_addr[1:0] != 2'b00);

endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the IMEM byte address and
// captures the returned word into the IF/ID register with PC+4 and valid.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = MIPS_RESET_PC,
  parameter int unsigned IMEM_WORDS = 128
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               flush,
  input  logic               branch_taken,
  input  logic signed [31:0] branch_imm,
  input  logic               jump,
  input  logic        [25:0] jump_index,
  input  logic               jump_reg,
  input  logic        [31:0] jr_addr,
  output logic        [31:0] read_addr,
  input  logic        [31:0] instruct,
  output logic        [31:0] ifid_instr,
  output logic        [31:0] ifid_pc_plus4,
  output logic               ifid_valid,
  output logic               fetch_fault
);

  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};
  localparam logic [31:0] IMEM_WORDS_W     = 32'(IMEM_WORDS);

  logic [31:0] pc_p0;
  logic [31:0] instr_p1;
  logic [31:0] pc_plus4_p1;
  logic        vld_p1;
  logic        fault_q;

  logic [31:0] pc_plus4;
  logic [31:0] word_idx;
  logic        in_range;
  npc_sel_e    npc_sel;
  logic [31:0] next_pc;
  logic        jr_misaligned;
  logic        redirect;

  assign pc_plus4 = pc_p0 + 32'd4;
  assign word_idx = {2'b00, pc_p0[31:2]};
  assign in_range = word_idx < IMEM_WORDS_W;
  assign redirect = (npc_sel != NPC_SEQ);

  pc_next_mux u_pc_next_mux (
    .seq_pc        (pc_plus4),
    .ifid_pc_plus4 (pc_plus4_p1),
    .ifid_valid    (vld_p1),
    .branch_taken  (branch_taken),
    .branch_imm    (branch_imm),
    .jump          (jump),
    .jump_index    (jump_index),
    .jump_reg      (jump_reg),
    .jr_addr       (jr_addr),
    .npc_sel       (npc_sel),
    .next_pc       (next_pc),
    .jr_misaligned (jr_misaligned)
  );

  // p0 -> p1: PC advance and IF/ID capture; stall freezes both, reset beats all.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_p0       <= RESET_PC_ALIGNED;
      instr_p1    <= MIPS_NOP;
      pc_plus4_p1 <= '0;
      vld_p1      <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      if (!in_range || (!stall && jr_misaligned)) fault_q <= 1'b1;
      if (!stall) begin
        pc_p0 <= next_pc;
        if (redirect || flush || !in_range) begin
          instr_p1 <= MIPS_NOP;
          vld_p1   <= 1'b0;
        end else begin
          instr_p1    <= instruct;
          pc_plus4_p1 <= pc_plus4;
          vld_p1      <= 1'b1;
        end
      end
    end
  end

  assign read_addr     = pc_p0;
  assign ifid_instr    = instr_p1;
  assign ifid_pc_plus4 = pc_plus4_p1;
  assign ifid_valid    = vld_p1;
  assign fetch_fault   = fault_q;

endmodule
